// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared response type and reference adder for adder_responder.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int WIDTH_DEFAULT = 2;

    typedef struct packed {
        logic                     cout;
        logic [WIDTH_DEFAULT-1:0] sum;
    } adder_rsp_t;

    function automatic adder_rsp_t add_ref(
        input logic [WIDTH_DEFAULT-1:0] a,
        input logic [WIDTH_DEFAULT-1:0] b,
        input logic                     cin
    );
        logic [WIDTH_DEFAULT:0] w_total;
        adder_rsp_t             w_rsp;
        w_total    = {1'b0, a} + {1'b0, b} + {{WIDTH_DEFAULT{1'b0}}, cin};
        w_rsp.cout = w_total[WIDTH_DEFAULT];
        w_rsp.sum  = w_total[WIDTH_DEFAULT-1:0];
        return w_rsp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : adder_rsp_fifo
// Brief    : Small in-order FIFO with modulo-DEPTH pointers (DEPTH need not be
//            a power of two) and an explicit occupancy counter.
// Revision : 1.0 - initial release
// ============================================================================
module adder_rsp_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [2:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_push_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    T                     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_OCC_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_full    = (r_count == c_OCC_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_OCC_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_OCC_W'(1);
            end
        end
    end

    // Storage is not reset: stale entries are never visible outside the
    // occupancy window and the top masks the head when empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_responder.sv
`default_nettype none
// ============================================================================
// Module   : adder_responder
// Brief    : Registered adder responder with valid/ready on both sides, an
//            in-order response FIFO and popped-transaction counters.
// Revision : 1.0 - initial release
// ============================================================================
module adder_responder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] cout_count
);

    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] sum;
    } rsp_t;

    rsp_t             w_result;
    rsp_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             r_ready_en;
    logic [CNT_W-1:0] r_txn_count;
    logic [CNT_W-1:0] r_cout_count;

    generate
        if (WIDTH == WIDTH_DEFAULT) begin : g_ref_add
            adder_rsp_t w_ref;
            assign w_ref    = add_ref(a, b, cin);
            assign w_result = {w_ref.cout, w_ref.sum};
        end else begin : g_generic_add
            assign w_result = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end
    endgenerate

    // req_ready depends only on registered state, so a full FIFO refuses a
    // push even if the head is popped in the same cycle.
    assign req_ready = r_ready_en && !w_full;
    assign rsp_valid = !w_empty;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;
    assign sum       = rsp_valid ? w_head.sum : '0;
    assign cout      = rsp_valid ? w_head.cout : 1'b0;
    assign txn_count  = r_txn_count;
    assign cout_count = r_cout_count;

    adder_rsp_fifo #(
        .DEPTH (DEPTH),
        .T     (rsp_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_result),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en   <= 1'b0;
            r_txn_count  <= '0;
            r_cout_count <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_pop) begin
                r_txn_count  <= r_txn_count + CNT_W'(1);
                r_cout_count <= r_cout_count + CNT_W'(w_head.cout);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_responder
// Brief    : Directed and scoreboarded bench for adder_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_responder;
    import adder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] a = '0;
    logic [1:0] b = '0;
    logic       cin = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] sum;
    logic       cout;
    logic [7:0] txn_count;
    logic [7:0] cout_count;

    logic       req_valid_w = 1'b0;
    logic       req_ready_w;
    logic [1:0] a_w = '0;
    logic [1:0] b_w = '0;
    logic       cin_w = 1'b0;
    logic       rsp_valid_w;
    logic       rsp_ready_w = 1'b0;
    logic [1:0] sum_w;
    logic       cout_w;
    logic [3:0] txn_count_w;
    logic [3:0] cout_count_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_responder #(.WIDTH(2), .DEPTH(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .b(b), .cin(cin), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .sum(sum), .cout(cout), .txn_count(txn_count), .cout_count(cout_count)
    );

    adder_responder #(.WIDTH(2), .DEPTH(2), .CNT_W(4)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_w), .req_ready(req_ready_w),
        .a(a_w), .b(b_w), .cin(cin_w), .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w),
        .sum(sum_w), .cout(cout_w), .txn_count(txn_count_w), .cout_count(cout_count_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({req_ready, rsp_valid, sum, cout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%b cout=%b, want all 0",
                     req_ready, rsp_valid, sum, cout);
        end
        checks++;
        if ({txn_count, cout_count} !== 16'h0) begin
            failures++;
            $display("FAIL reset_counters: got txn=%0d cout=%0d, want 0 0", txn_count, cout_count);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_basic();
        rsp_ready = 1'b1;
        req_valid = 1'b1; a = 2'b01; b = 2'b10; cin = 1'b0;
        step();
        req_valid = 1'b0; a = 'x; b = 'x; cin = 'x;
        checks++;
        if ({rsp_valid, cout, sum} !== 4'b1_0_11) begin
            failures++;
            $display("FAIL basic1_rsp: got vld=%b cout=%b sum=%b want 1 0 11", rsp_valid, cout, sum);
        end
        step();
        checks++;
        if (txn_count !== 8'd1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic1_count: got txn=%0d vld=%b want 1 0", txn_count, rsp_valid);
        end
        req_valid = 1'b1; a = 2'b11; b = 2'b01; cin = 1'b1;
        step();
        req_valid = 1'b0; a = 'x; b = 'x; cin = 'x;
        checks++;
        if ({rsp_valid, cout, sum} !== 4'b1_1_01) begin
            failures++;
            $display("FAIL basic2_rsp: got vld=%b cout=%b sum=%b want 1 1 01", rsp_valid, cout, sum);
        end
        step();
        checks++;
        if (txn_count !== 8'd2 || cout_count !== 8'd1) begin
            failures++;
            $display("FAIL basic2_count: got txn=%0d cout=%0d want 2 1", txn_count, cout_count);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_rsp [3];
        int         idx;
        int         cyc;
        logic       acc;
        exp_rsp[0] = 3'b0_10;
        exp_rsp[1] = 3'b1_00;
        exp_rsp[2] = 3'b1_11;
        rsp_ready = 1'b0;
        req_valid = 1'b1; a = 2'b01; b = 2'b01; cin = 1'b0;
        step();
        a = 2'b10; b = 2'b10; cin = 1'b0;
        step();
        a = 2'b11; b = 2'b11; cin = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_ready: got %b want 0", req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({rsp_valid, cout, sum} !== 4'b1_0_10 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall_hold: cyc %0d got vld=%b cout=%b sum=%b rdy=%b want 1 0 10 0",
                         i, rsp_valid, cout, sum, req_ready);
            end
        end
        rsp_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 3 && cyc < 12) begin
            acc = req_valid && req_ready;
            checks++;
            if (rsp_valid !== 1'b1 || {cout, sum} !== exp_rsp[idx]) begin
                failures++;
                $display("FAIL bp_drain_order: idx %0d got vld=%b rsp=%b want 1 %b",
                         idx, rsp_valid, {cout, sum}, exp_rsp[idx]);
            end
            idx++;
            step();
            cyc++;
            if (acc) begin
                req_valid = 1'b0; a = 'x; b = 'x; cin = 'x;
            end
        end
        checks++;
        if (rsp_valid !== 1'b0 || req_valid !== 1'b0 || txn_count !== 8'd5 || cout_count !== 8'd3) begin
            failures++;
            $display("FAIL bp_final: got vld=%b reqv=%b txn=%0d cout=%0d want 0 0 5 3",
                     rsp_valid, req_valid, txn_count, cout_count);
        end
    endtask

    task automatic test_full_pop_random();
        adder_rsp_t q[$];
        adder_rsp_t exp_r;
        int         n_acc = 0;
        int         cyc = 0;
        int         m_txn = 5;
        int         m_cout = 3;
        logic       acc;
        logic       pp;
        req_valid = 1'b1;
        a = 2'($urandom); b = 2'($urandom); cin = 1'($urandom);
        while ((n_acc < 50 || q.size() != 0) && cyc < 2000) begin
            rsp_ready = (n_acc >= 50) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            acc = req_valid && req_ready;
            pp  = rsp_valid && rsp_ready;
            if (pp) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra_rsp: got rsp=%b with empty scoreboard", {cout, sum});
                end else begin
                    exp_r = q.pop_front();
                    m_txn++;
                    m_cout += int'(exp_r.cout);
                    if ({cout, sum} !== exp_r) begin
                        failures++;
                        $display("FAIL rand_rsp: got %b want %b", {cout, sum}, exp_r);
                    end
                end
            end
            if (acc) begin
                q.push_back(add_ref(a, b, cin));
            end
            step();
            cyc++;
            if (acc) n_acc++;
            if (n_acc < 50 && $urandom_range(0, 3) != 0) begin
                req_valid = 1'b1;
                a = 2'($urandom); b = 2'($urandom); cin = 1'($urandom);
            end else begin
                req_valid = 1'b0; a = 'x; b = 'x; cin = 'x;
            end
        end
        checks++;
        if (cyc >= 2000 || n_acc != 50) begin
            failures++;
            $display("FAIL rand_timeout: got accepts=%0d cycles=%0d want 50 within 2000", n_acc, cyc);
        end
        checks++;
        if (txn_count !== 8'(m_txn) || cout_count !== 8'(m_cout)) begin
            failures++;
            $display("FAIL rand_counters: got txn=%0d cout=%0d want %0d %0d",
                     txn_count, cout_count, m_txn, m_cout);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 1'b1; a = 2'b10; b = 2'b11; cin = 1'b0;
        step();
        a = 2'b11; b = 2'b11; cin = 1'b0;
        step();
        req_valid = 1'b0; a = 'x; b = 'x; cin = 'x;
        checks++;
        if ({rsp_valid, cout, sum} !== 4'b1_1_01) begin
            failures++;
            $display("FAIL rstmid_pending: got vld=%b cout=%b sum=%b want 1 1 01", rsp_valid, cout, sum);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, cout, sum} !== 5'b0 || {txn_count, cout_count} !== 16'h0) begin
            failures++;
            $display("FAIL rstmid_async: got rdy=%b vld=%b cout=%b sum=%b txn=%0d cc=%0d want all 0",
                     req_ready, rsp_valid, cout, sum, txn_count, cout_count);
        end
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_release: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
        end
        req_valid = 1'b1; a = 2'b01; b = 2'b01; cin = 1'b1;
        step();
        req_valid = 1'b0; a = 'x; b = 'x; cin = 'x;
        checks++;
        if ({rsp_valid, cout, sum} !== 4'b1_0_11) begin
            failures++;
            $display("FAIL rstmid_fresh: got vld=%b cout=%b sum=%b want 1 0 11", rsp_valid, cout, sum);
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (txn_count !== 8'd1 || cout_count !== 8'd0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_count: got txn=%0d cc=%0d vld=%b want 1 0 0",
                     txn_count, cout_count, rsp_valid);
        end
    endtask

    task automatic test_counter_wrap();
        int   n_acc = 0;
        int   n_pop = 0;
        int   cyc = 0;
        logic acc;
        rsp_ready_w = 1'b1;
        req_valid_w = 1'b1; a_w = 2'b11; b_w = 2'b11; cin_w = 1'b1;
        while ((n_acc < 17 || rsp_valid_w) && cyc < 100) begin
            acc = req_valid_w && req_ready_w;
            if (rsp_valid_w) begin
                n_pop++;
                checks++;
                if ({cout_w, sum_w} !== 3'b1_11) begin
                    failures++;
                    $display("FAIL wrap_rsp: pop %0d got %b want 111", n_pop, {cout_w, sum_w});
                end
            end
            step();
            cyc++;
            if (acc) n_acc++;
            if (n_acc >= 17) req_valid_w = 1'b0;
        end
        checks++;
        if (n_pop != 17 || txn_count_w !== 4'd1 || cout_count_w !== 4'd1) begin
            failures++;
            $display("FAIL wrap_counters: got pops=%0d txn=%0d cc=%0d want 17 1 1",
                     n_pop, txn_count_w, cout_count_w);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pop_random();
        test_reset_mid();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
